// File: rtl/sync_fifo_mc_pkg.sv
// rtl/sync_fifo_mc_pkg.sv - shared width derivations for the multi-channel FIFO blocks
package sync_fifo_mc_pkg;

    // Channel-select width never collapses to zero, so a single-channel build still has a port.
    function automatic int fifo_ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // One extra bit lets the count represent a completely full channel.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int fifo_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_ch_ctrl.sv
// rtl/fifo_ch_ctrl.sv - per-channel pointers, occupancy count, status and sticky error flags
module fifo_ch_ctrl
    import sync_fifo_mc_pkg::*;
#(
    parameter int MEM_DEPTH = 8,
    parameter int AF_LEVEL  = MEM_DEPTH - 2,
    parameter int PTR_W     = fifo_ptr_w(MEM_DEPTH),
    parameter int CNT_W     = fifo_cnt_w(MEM_DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_wr_req,
    input  logic             i_rd_req,
    input  logic             i_clr_err,
    output logic             o_wr_acc,
    output logic             o_rd_acc,
    output logic [PTR_W-1:0] o_wr_ptr,
    output logic [PTR_W-1:0] o_rd_ptr,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_almost_full,
    output logic             o_overflow,
    output logic             o_underflow
);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_empty;
    logic             r_almost_full;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Judged against the registered flags: full lets the read win, empty lets the write win.
    assign w_wr_acc = i_wr_req & ~r_full;
    assign w_rd_acc = i_rd_req & ~r_empty;

    always_comb begin
        w_cnt_nxt = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_cnt_nxt = r_count + 1'b1;
        end else if (!w_wr_acc && w_rd_acc) begin
            w_cnt_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_full        <= 1'b0;
            r_empty       <= 1'b1;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count       <= w_cnt_nxt;
            r_full        <= (w_cnt_nxt == CNT_W'(MEM_DEPTH));
            r_empty       <= (w_cnt_nxt == '0);
            r_almost_full <= (w_cnt_nxt >= CNT_W'(AF_LEVEL));
            // A fresh rejection in the clearing cycle keeps its bit set.
            r_overflow    <= (r_overflow  & ~i_clr_err) | (i_wr_req & ~w_wr_acc);
            r_underflow   <= (r_underflow & ~i_clr_err) | (i_rd_req & ~w_rd_acc);
        end
    end

    assign o_wr_acc      = w_wr_acc;
    assign o_rd_acc      = w_rd_acc;
    assign o_wr_ptr      = r_wr_ptr;
    assign o_rd_ptr      = r_rd_ptr;
    assign o_full        = r_full;
    assign o_empty       = r_empty;
    assign o_almost_full = r_almost_full;
    assign o_overflow    = r_overflow;
    assign o_underflow   = r_underflow;

endmodule

// File: rtl/sync_fifo_mc.sv
// rtl/sync_fifo_mc.sv - NUM_CH independent FIFOs sharing one storage array and one read port
module sync_fifo_mc
    import sync_fifo_mc_pkg::*;
#(
    parameter int  DATA_WIDTH = 8,
    parameter int  MEM_DEPTH  = 8,
    parameter int  NUM_CH     = 4,
    parameter int  AF_LEVEL   = MEM_DEPTH - 2,
    localparam int CH_W       = fifo_ch_w(NUM_CH),
    localparam int CNT_W      = fifo_cnt_w(MEM_DEPTH),
    localparam int PTR_W      = fifo_ptr_w(MEM_DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WR_EN,
    input  logic [CH_W-1:0]       WR_CH,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  RD_EN,
    input  logic [CH_W-1:0]       RD_CH,
    input  logic                  CLR_ERR,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  RD_VALID,
    output logic [NUM_CH-1:0]     FULL,
    output logic [NUM_CH-1:0]     EMPTY,
    output logic [NUM_CH-1:0]     ALMOST_FULL,
    output logic [NUM_CH-1:0]     OVERFLOW,
    output logic [NUM_CH-1:0]     UNDERFLOW
);

    logic [DATA_WIDTH-1:0] r_mem [NUM_CH*MEM_DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;

    logic [NUM_CH-1:0]     w_wr_req;
    logic [NUM_CH-1:0]     w_rd_req;
    logic [NUM_CH-1:0]     w_wr_acc;
    logic [NUM_CH-1:0]     w_rd_acc;
    logic [PTR_W-1:0]      w_wr_ptr [NUM_CH];
    logic [PTR_W-1:0]      w_rd_ptr [NUM_CH];
    logic [CH_W+PTR_W-1:0] w_wr_addr;
    logic [CH_W+PTR_W-1:0] w_rd_addr;

    // Channel codes at or above NUM_CH match no decoder output, so they never reach a channel.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_wr_req[g] = WR_EN & ~RST & (WR_CH == CH_W'(g));
        assign w_rd_req[g] = RD_EN & ~RST & (RD_CH == CH_W'(g));

        fifo_ch_ctrl #(
            .MEM_DEPTH (MEM_DEPTH),
            .AF_LEVEL  (AF_LEVEL),
            .PTR_W     (PTR_W),
            .CNT_W     (CNT_W)
        ) u_ctrl (
            .CLK           (CLK),
            .RST           (RST),
            .i_wr_req      (w_wr_req[g]),
            .i_rd_req      (w_rd_req[g]),
            .i_clr_err     (CLR_ERR),
            .o_wr_acc      (w_wr_acc[g]),
            .o_rd_acc      (w_rd_acc[g]),
            .o_wr_ptr      (w_wr_ptr[g]),
            .o_rd_ptr      (w_rd_ptr[g]),
            .o_full        (FULL[g]),
            .o_empty       (EMPTY[g]),
            .o_almost_full (ALMOST_FULL[g]),
            .o_overflow    (OVERFLOW[g]),
            .o_underflow   (UNDERFLOW[g])
        );
    end

    always_comb begin
        w_wr_addr = '0;
        w_rd_addr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_wr_req[i]) begin
                w_wr_addr = {CH_W'(i), w_wr_ptr[i]};
            end
            if (w_rd_req[i]) begin
                w_rd_addr = {CH_W'(i), w_rd_ptr[i]};
            end
        end
    end

    // Storage is never reset; pointer reset alone discards queued words.
    always_ff @(posedge CLK) begin
        if (|w_wr_acc) begin
            r_mem[w_wr_addr] <= WR_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= |w_rd_acc;
            if (|w_rd_acc) begin
                r_rd_data <= r_mem[w_rd_addr];
            end
        end
    end

    assign RD_DATA  = r_rd_data;
    assign RD_VALID = r_rd_valid;

endmodule

// File: tb/tb_sync_fifo_mc.sv
// tb/tb_sync_fifo_mc.sv - directed vector table plus wrap, reset and channel-range sequences
module tb_sync_fifo_mc;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, wr_en, rd_en, clr_err;
    logic [1:0] wr_ch, rd_ch;
    logic [7:0] wr_data, rd_data;
    logic       rd_valid;
    logic [3:0] full, empty, almost_full, overflow, underflow;

    logic       e_rst, e_wr_en, e_rd_en, e_clr_err;
    logic [2:0] e_wr_ch, e_rd_ch;
    logic [7:0] e_wr_data, e_rd_data;
    logic       e_rd_valid;
    logic [4:0] e_full, e_empty, e_almost_full, e_overflow, e_underflow;

    sync_fifo_mc u_dut (
        .CLK(clk), .RST(rst), .WR_EN(wr_en), .WR_CH(wr_ch), .WR_DATA(wr_data),
        .RD_EN(rd_en), .RD_CH(rd_ch), .CLR_ERR(clr_err), .RD_DATA(rd_data),
        .RD_VALID(rd_valid), .FULL(full), .EMPTY(empty), .ALMOST_FULL(almost_full),
        .OVERFLOW(overflow), .UNDERFLOW(underflow)
    );

    sync_fifo_mc #(.NUM_CH(5)) u_dut5 (
        .CLK(clk), .RST(e_rst), .WR_EN(e_wr_en), .WR_CH(e_wr_ch), .WR_DATA(e_wr_data),
        .RD_EN(e_rd_en), .RD_CH(e_rd_ch), .CLR_ERR(e_clr_err), .RD_DATA(e_rd_data),
        .RD_VALID(e_rd_valid), .FULL(e_full), .EMPTY(e_empty), .ALMOST_FULL(e_almost_full),
        .OVERFLOW(e_overflow), .UNDERFLOW(e_underflow)
    );

    typedef struct {
        logic       rst, we;
        logic [1:0] wch;
        logic [7:0] wd;
        logic       re;
        logic [1:0] rch;
        logic       clr;
        logic       vld;
        logic [7:0] data;
        logic [3:0] full, empty, af, ovf, unf;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] model[$];
    int         n_pass  = 0;
    int         n_total = 0;

    task automatic add(input logic r, we, input logic [1:0] wch, input logic [7:0] wd,
                       input logic re, input logic [1:0] rch, input logic clr,
                       input logic vld, input logic [7:0] data,
                       input logic [3:0] f, e, af, ov, un);
        vec_t v;
        v.rst = r; v.we = we; v.wch = wch; v.wd = wd; v.re = re; v.rch = rch; v.clr = clr;
        v.vld = vld; v.data = data; v.full = f; v.empty = e; v.af = af; v.ovf = ov; v.unf = un;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic r, we, input logic [1:0] wch, input logic [7:0] wd,
                         input logic re, input logic [1:0] rch, input logic clr);
        rst = r; wr_en = we; wr_ch = wch; wr_data = wd; rd_en = re; rd_ch = rch; clr_err = clr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1, 0, 0, 8'h00, 0, 0, 0);
        e_rst = 1; e_wr_en = 0; e_wr_ch = 0; e_wr_data = 0; e_rd_en = 0; e_rd_ch = 0; e_clr_err = 0;
        step(); step();

        //  rst we ch data   re ch clr | vld data  full  empty af    ovf   unf
        add(1, 0, 0, 8'h00, 0, 0, 0,    0, 8'h00, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
        add(0, 1, 0, 8'h11, 0, 0, 0,    0, 8'h00, 4'h0, 4'hE, 4'h0, 4'h0, 4'h0);
        add(0, 1, 0, 8'h12, 0, 0, 0,    0, 8'h00, 4'h0, 4'hE, 4'h0, 4'h0, 4'h0);
        add(0, 1, 0, 8'h13, 0, 0, 0,    0, 8'h00, 4'h0, 4'hE, 4'h0, 4'h0, 4'h0);
        add(0, 1, 0, 8'h14, 0, 0, 0,    0, 8'h00, 4'h0, 4'hE, 4'h0, 4'h0, 4'h0);
        add(0, 1, 0, 8'h15, 0, 0, 0,    0, 8'h00, 4'h0, 4'hE, 4'h0, 4'h0, 4'h0);
        add(0, 1, 0, 8'h16, 0, 0, 0,    0, 8'h00, 4'h0, 4'hE, 4'h1, 4'h0, 4'h0);
        add(0, 1, 0, 8'h17, 0, 0, 0,    0, 8'h00, 4'h0, 4'hE, 4'h1, 4'h0, 4'h0);
        add(0, 1, 0, 8'h18, 0, 0, 0,    0, 8'h00, 4'h1, 4'hE, 4'h1, 4'h0, 4'h0);
        add(0, 1, 0, 8'h99, 0, 0, 0,    0, 8'h00, 4'h1, 4'hE, 4'h1, 4'h1, 4'h0);
        add(0, 0, 0, 8'h00, 0, 0, 1,    0, 8'h00, 4'h1, 4'hE, 4'h1, 4'h0, 4'h0);
        add(0, 0, 0, 8'h00, 1, 0, 0,    1, 8'h11, 4'h0, 4'hE, 4'h1, 4'h0, 4'h0);
        add(0, 0, 0, 8'h00, 1, 0, 0,    1, 8'h12, 4'h0, 4'hE, 4'h1, 4'h0, 4'h0);
        add(0, 0, 0, 8'h00, 1, 0, 0,    1, 8'h13, 4'h0, 4'hE, 4'h0, 4'h0, 4'h0);
        add(0, 0, 0, 8'h00, 1, 0, 0,    1, 8'h14, 4'h0, 4'hE, 4'h0, 4'h0, 4'h0);
        add(0, 0, 0, 8'h00, 1, 0, 0,    1, 8'h15, 4'h0, 4'hE, 4'h0, 4'h0, 4'h0);
        add(0, 0, 0, 8'h00, 1, 0, 0,    1, 8'h16, 4'h0, 4'hE, 4'h0, 4'h0, 4'h0);
        add(0, 0, 0, 8'h00, 1, 0, 0,    1, 8'h17, 4'h0, 4'hE, 4'h0, 4'h0, 4'h0);
        add(0, 0, 0, 8'h00, 1, 0, 0,    1, 8'h18, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
        add(0, 0, 0, 8'h00, 1, 0, 0,    0, 8'h18, 4'h0, 4'hF, 4'h0, 4'h0, 4'h1);
        add(0, 0, 0, 8'h00, 1, 3, 1,    0, 8'h18, 4'h0, 4'hF, 4'h0, 4'h0, 4'h8);
        add(0, 0, 0, 8'h00, 0, 0, 1,    0, 8'h18, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
        add(0, 1, 2, 8'h21, 0, 0, 0,    0, 8'h18, 4'h0, 4'hB, 4'h0, 4'h0, 4'h0);
        add(0, 1, 2, 8'h22, 0, 0, 0,    0, 8'h18, 4'h0, 4'hB, 4'h0, 4'h0, 4'h0);
        add(0, 1, 2, 8'h23, 0, 0, 0,    0, 8'h18, 4'h0, 4'hB, 4'h0, 4'h0, 4'h0);
        add(0, 1, 2, 8'h24, 0, 0, 0,    0, 8'h18, 4'h0, 4'hB, 4'h0, 4'h0, 4'h0);
        add(0, 1, 2, 8'h25, 0, 0, 0,    0, 8'h18, 4'h0, 4'hB, 4'h0, 4'h0, 4'h0);
        add(0, 1, 2, 8'h26, 0, 0, 0,    0, 8'h18, 4'h0, 4'hB, 4'h4, 4'h0, 4'h0);
        add(0, 1, 2, 8'h27, 0, 0, 0,    0, 8'h18, 4'h0, 4'hB, 4'h4, 4'h0, 4'h0);
        add(0, 1, 2, 8'h28, 0, 0, 0,    0, 8'h18, 4'h4, 4'hB, 4'h4, 4'h0, 4'h0);
        add(0, 1, 2, 8'hAA, 1, 2, 0,    1, 8'h21, 4'h0, 4'hB, 4'h4, 4'h4, 4'h0);
        add(0, 0, 0, 8'h00, 0, 0, 1,    0, 8'h21, 4'h0, 4'hB, 4'h4, 4'h0, 4'h0);
        add(0, 1, 2, 8'h29, 0, 0, 0,    0, 8'h21, 4'h4, 4'hB, 4'h4, 4'h0, 4'h0);
        add(0, 1, 1, 8'h31, 1, 2, 0,    1, 8'h22, 4'h0, 4'h9, 4'h4, 4'h0, 4'h0);
        add(0, 1, 3, 8'h41, 1, 3, 0,    0, 8'h22, 4'h0, 4'h1, 4'h4, 4'h0, 4'h8);
        add(0, 0, 0, 8'h00, 1, 3, 1,    1, 8'h41, 4'h0, 4'h9, 4'h4, 4'h0, 4'h0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].we, vecs[i].wch, vecs[i].wd, vecs[i].re, vecs[i].rch, vecs[i].clr);
            step();
            check($sformatf("vec%0d", i),
                  {rd_valid, rd_data, full, empty, almost_full, overflow, underflow},
                  {vecs[i].vld, vecs[i].data, vecs[i].full, vecs[i].empty, vecs[i].af,
                   vecs[i].ovf, vecs[i].unf});
        end

        // ch1 held at three words for 20 read+write cycles: both pointers wrap twice.
        drive(1, 0, 0, 8'h00, 0, 0, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 8'h50 + 8'(i), 0, 0, 0);
            model.push_back(8'h50 + 8'(i));
            step();
        end
        for (int i = 0; i < 20; i++) begin
            logic [7:0] exp_d;
            drive(0, 1, 1, 8'h60 + 8'(i), 1, 1, 0);
            step();
            exp_d = model.pop_front();
            model.push_back(8'h60 + 8'(i));
            check($sformatf("wrap_rd%0d", i), {rd_valid, rd_data}, {1'b1, exp_d});
        end
        drive(0, 0, 0, 8'h00, 0, 0, 0);
        step();
        check("wrap_flags", {full, empty, almost_full, overflow, underflow},
              {4'h0, 4'hD, 4'h0, 4'h0, 4'h0});
        for (int i = 0; i < 3; i++) begin
            logic [7:0] exp_d;
            drive(0, 0, 0, 8'h00, 1, 1, 0);
            step();
            exp_d = model.pop_front();
            check($sformatf("drain_rd%0d", i), {rd_valid, rd_data}, {1'b1, exp_d});
        end
        drive(0, 0, 0, 8'h00, 0, 0, 0);
        step();
        check("drain_empty", empty, 4'hF);

        // Reset with four queued words, and a read request in the reset cycle that must be ignored.
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 8'h71 + 8'(i), 0, 0, 0);
            step();
        end
        check("pre_rst_empty", empty, 4'hE);
        drive(1, 0, 0, 8'h00, 1, 0, 0);
        step();
        check("mid_rst", {rd_valid, rd_data, full, empty, almost_full, overflow, underflow},
              {1'b0, 8'h00, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0});
        drive(0, 0, 0, 8'h00, 1, 0, 0);
        step();
        check("post_rst_rd", {rd_valid, underflow}, {1'b0, 4'h1});
        drive(0, 0, 0, 8'h00, 0, 0, 0);

        // Five-channel instance: codes 5..7 are out of range and must be silently dropped.
        e_rst = 1; step(); e_rst = 0;
        e_wr_en = 1; e_wr_ch = 3'd5; e_wr_data = 8'hAA; e_rd_en = 1; e_rd_ch = 3'd6;
        step();
        check("oor_5_6", {e_rd_valid, e_overflow, e_underflow, e_empty}, {1'b0, 5'h00, 5'h00, 5'h1F});
        e_wr_ch = 3'd7; e_rd_ch = 3'd7;
        step();
        check("oor_7", {e_rd_valid, e_overflow, e_underflow, e_empty}, {1'b0, 5'h00, 5'h00, 5'h1F});
        e_wr_ch = 3'd4; e_wr_data = 8'h5A; e_rd_en = 0;
        step();
        check("ch4_wr", e_empty, 5'h0F);
        e_wr_en = 0; e_rd_en = 1; e_rd_ch = 3'd4;
        step();
        check("ch4_rd", {e_rd_valid, e_rd_data}, {1'b1, 8'h5A});
        step();
        check("ch4_unf", {e_rd_valid, e_underflow, e_empty}, {1'b0, 5'h10, 5'h1F});
        e_rd_en = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
